bus_unpack: RTL and testbench

//  Inverse of the bus packer: takes 7-bit packed words {a[2:0], b[1:0], tag[1:0]} and splits them back into a/b fields.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_fifo2.sv | 64 ++++++
 rtl/bus_unpack.sv | 54 +++++
 tb/tb_bus_unpack.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the packed {a, b, tag} bus used by the packer and unpacker.
package bus_pkg;

  localparam int unsigned A_W   = 3;
  localparam int unsigned B_W   = 2;
  localparam int unsigned TAG_W = 2;
  localparam int unsigned W     = A_W + B_W + TAG_W;
  localparam int unsigned CNT_W = 8;

  localparam logic [TAG_W-1:0] TAG = 2'b10;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } bus_fields_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/bus_fifo2.sv
// Two-entry FIFO of bus_fields_t with a registered head, registered valid and registered push-ready.
module bus_fifo2
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  bus_fields_t din,
  output bus_fields_t dout,
  output logic        dout_valid,
  output logic        push_ok
);

  buf_state_t  state, state_n;
  bus_fields_t mem [2];
  bus_fields_t mem_n [2];
  logic        wr_ptr, rd_ptr;
  logic        wr_ptr_n, rd_ptr_n;
  logic        wr, rd;

  // Next-state, pointer and storage update; FULL never accepts, EMPTY never pops.
  always_comb begin
    wr       = push && push_ok;
    rd       = pop && dout_valid;
    mem_n    = mem;
    wr_ptr_n = wr_ptr ^ wr;
    rd_ptr_n = rd_ptr ^ rd;
    state_n  = state;
    if (wr) mem_n[wr_ptr] = din;
    unique case (state)
      EMPTY: if (wr) state_n = ONE;
      ONE: begin
        if (wr && !rd)      state_n = FULL;
        else if (!wr && rd) state_n = EMPTY;
      end
      FULL:    if (rd) state_n = ONE;
      default: state_n = EMPTY;
    endcase
  end

  // The head register only reloads while data remains, so it holds the last popped word when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      push_ok    <= 1'b0;
    end else begin
      state      <= state_n;
      mem        <= mem_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      dout_valid <= (state_n != EMPTY);
      push_ok    <= (state_n != FULL);
      if (state_n != EMPTY) dout <= mem_n[rd_ptr_n];
    end
  end

endmodule

// File: rtl/bus_unpack.sv
// Splits packed {a, b, tag} words into fields, dropping and counting words with a bad tag.
module bus_unpack
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [A_W-1:0]   out_a,
  output logic [B_W-1:0]   out_b,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  bus_fields_t fields_c;
  bus_fields_t head;
  logic        accept_c;
  logic        tag_ok_c;

  assign accept_c   = in_valid && in_ready;
  assign tag_ok_c   = (in_word[TAG_W-1:0] == TAG);
  assign fields_c.a = in_word[W-1 -: A_W];
  assign fields_c.b = in_word[W-A_W-1 -: B_W];

  bus_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept_c && tag_ok_c),
    .pop        (out_ready),
    .din        (fields_c),
    .dout       (head),
    .dout_valid (out_valid),
    .push_ok    (in_ready)
  );

  assign out_a = head.a;
  assign out_b = head.b;

  // Malformed words still complete the handshake; they only raise a pulse and bump the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= accept_c && !tag_ok_c;
      if (accept_c && !tag_ok_c && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_unpack.sv
// Self-checking bench for bus_unpack: directed vector table, hand sequences and a random run vs a queue model.
module tb_bus_unpack;
  import bus_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_word;
  logic             out_valid;
  logic             out_ready;
  logic [A_W-1:0]   out_a;
  logic [B_W-1:0]   out_b;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  // Reference model: a queue of {a,b} pairs plus the last value shown on the outputs.
  logic [A_W+B_W-1:0] mq[$];
  logic [A_W+B_W-1:0] m_shown;
  logic               m_run;
  logic               m_pulse;
  int                 m_cnt;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare everything against it.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] w, input logic ordy);
    logic acc, pop, good;
    @(negedge clk);
    rst_n = r; in_valid = iv; in_word = w; out_ready = ordy;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      m_shown = '0; m_run = 1'b0; m_pulse = 1'b0; m_cnt = 0;
    end else begin
      acc  = iv && m_run && (mq.size() < 2);
      pop  = (mq.size() > 0) && ordy;
      good = (w[TAG_W-1:0] == TAG);
      if (pop) void'(mq.pop_front());
      if (acc && good) mq.push_back(w[W-1:TAG_W]);
      m_pulse = acc && !good;
      if (m_pulse && m_cnt < 255) m_cnt++;
      m_run = 1'b1;
      if (mq.size() > 0) m_shown = mq[0];
    end
    #1;
    check("model_out_valid", int'(out_valid), int'(mq.size() > 0));
    check("model_in_ready", int'(in_ready), int'(m_run && (mq.size() < 2)));
    check("model_out_a", int'(out_a), int'(m_shown[A_W+B_W-1:B_W]));
    check("model_out_b", int'(out_b), int'(m_shown[B_W-1:0]));
    check("model_err_pulse", int'(err_pulse), int'(m_pulse));
    check("model_err_count", int'(err_count), m_cnt);
  endtask

  typedef struct {
    logic         r;
    logic         iv;
    logic [W-1:0] w;
    logic         ordy;
    logic         e_valid;
    int           e_a;
    int           e_b;
    logic         e_ready;
    logic         e_pulse;
    int           e_cnt;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [W-1:0] w;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;

    //        r  iv  word         ordy vld a  b  rdy pls cnt
    vt[0]  = '{0, 0, 7'b000_00_00, 0,  0,  0, 0, 0,  0,  0};
    vt[1]  = '{0, 0, 7'b000_00_00, 0,  0,  0, 0, 0,  0,  0};
    vt[2]  = '{1, 0, 7'b000_00_00, 1,  0,  0, 0, 1,  0,  0};
    vt[3]  = '{1, 1, 7'b111_00_10, 1,  1,  7, 0, 1,  0,  0};
    vt[4]  = '{1, 0, 7'b000_00_00, 1,  0,  7, 0, 1,  0,  0};
    vt[5]  = '{1, 1, 7'b101_00_11, 1,  0,  7, 0, 1,  1,  1};
    vt[6]  = '{1, 1, 7'b101_00_10, 1,  1,  5, 0, 1,  0,  1};
    vt[7]  = '{1, 0, 7'b000_00_00, 1,  0,  5, 0, 1,  0,  1};
    vt[8]  = '{1, 1, 7'b111_11_10, 0,  1,  7, 3, 1,  0,  1};
    vt[9]  = '{1, 1, 7'b101_00_10, 0,  1,  7, 3, 0,  0,  1};
    vt[10] = '{1, 1, 7'b011_01_10, 0,  1,  7, 3, 0,  0,  1};
    vt[11] = '{1, 1, 7'b011_01_10, 1,  1,  5, 0, 1,  0,  1};
    vt[12] = '{1, 1, 7'b011_01_10, 1,  1,  3, 1, 1,  0,  1};
    vt[13] = '{1, 0, 7'b000_00_00, 1,  0,  3, 1, 1,  0,  1};

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].iv, vt[i].w, vt[i].ordy);
      check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].e_valid));
      check($sformatf("vec%0d_out_a", i), int'(out_a), vt[i].e_a);
      check($sformatf("vec%0d_out_b", i), int'(out_b), vt[i].e_b);
      check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].e_ready));
      check($sformatf("vec%0d_err_pulse", i), int'(err_pulse), int'(vt[i].e_pulse));
      check($sformatf("vec%0d_err_count", i), int'(err_count), vt[i].e_cnt);
    end

    // Streaming in ONE: push and pop every cycle, one-cycle latency, never stalls.
    for (int i = 0; i < 4; i++) begin
      a = A_W'(i + 2); b = B_W'(3 - i);
      w = {a, b, TAG};
      step(1'b1, 1'b1, w, 1'b1);
      check("stream_valid", int'(out_valid), 1);
      check("stream_ready", int'(in_ready), 1);
      check("stream_a", int'(out_a), i + 2);
      check("stream_b", int'(out_b), 3 - i);
    end
    step(1'b1, 1'b0, '0, 1'b1);
    check("stream_drain_valid", int'(out_valid), 0);

    // Counter saturation after 260 malformed words.
    for (int i = 0; i < 260; i++) begin
      w = W'($urandom);
      w[TAG_W-1:0] = (i % 2 == 0) ? 2'b00 : 2'b11;
      step(1'b1, 1'b1, w, 1'b1);
    end
    check("sat_err_count", int'(err_count), 255);
    check("sat_no_valid", int'(out_valid), 0);

    // Fill to FULL, then reset mid-operation.
    step(1'b1, 1'b1, 7'b110_10_10, 1'b0);
    step(1'b1, 1'b1, 7'b001_01_10, 1'b0);
    check("full_in_ready", int'(in_ready), 0);
    step(1'b0, 1'b1, 7'b111_11_10, 1'b1);
    check("rst_valid", int'(out_valid), 0);
    check("rst_a", int'(out_a), 0);
    check("rst_b", int'(out_b), 0);
    check("rst_count", int'(err_count), 0);
    check("rst_in_ready", int'(in_ready), 0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_rst_valid", int'(out_valid), 0);
    check("post_rst_ready", int'(in_ready), 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      w = W'($urandom);
      if ($urandom_range(3) != 0) w[TAG_W-1:0] = TAG;
      step(($urandom_range(99) != 0), 1'($urandom), w, ($urandom_range(2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
